fir_trig_discr: RTL
===================

// Module: fir_trig_discr
// PURPOSE
//  Discriminator stage directly downstream of the FIR trigger: turns the 4 parallel TOT bits into
//  discrete trigger events. Each event carries a sample-resolution timestamp, TOT length, latched
//  baseline sum and flags, and is queued in an event FIFO drained via valid/ready by the readout logic.
// PARAMETERS
//  FIFO_DEPTH  16  event FIFO entries; power of 2, >=2
//  CNT_BITS    16  width of TOT length, holdoff and drop counters
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   async active-low reset
//  tot_in         in   4   TOT bits; lane 0 = earliest sample of the word
//  fvalid_in      in   1   filter output valid, aligned with tot_in
//  fout_in        in   124 filtered samples {lane3..lane0}, 31b signed each, aligned with tot_in
//  bsum_in        in   18  baseline sum, aligned with tot_in
//  ltc_in         in   48  clock-cycle timestamp of the current tot_in word
//  enable         in   1   discriminator enable (level)
//  holdoff        in   CNT_BITS  dead time after an event, in clk cycles (0 treated as 1)
//  max_tot        in   CNT_BITS  TOT truncation length in samples; 0 = unlimited
//  drop_cnt_clr   in   1   sync clear of drop_cnt
//  evt_valid      out  1   FIFO head valid
//  evt_ready      in   1   consumer accepts head when evt_valid && evt_ready
//  evt_ts         out  50  {ltc, lane} of rising sample
//  evt_tot        out  CNT_BITS  TOT length in samples
//  evt_bsum       out  18  bsum_in latched in the rising word
//  evt_peak       out  31  peak filtered value during TOT (see CONFIGURATION)
//  evt_flags      out  2   [0] truncated at max_tot, [1] terminated by fvalid_in low
//  drop_cnt       out  CNT_BITS  saturating count of events lost to a full FIFO
// BEHAVIOUR
//  Reset: state IDLE; FIFO empty; evt_valid=0; all evt_* outputs, drop_cnt, counters = 0.
//  Effective TOT t[i] = tot_in[i] & fvalid_in. Previous-sample bit for lane 0 = lane 3 of the
//  prior word (0 after reset or in IDLE).
//  FSM:
//   IDLE    : enable=1 -> ARMED. enable=0 in any state -> IDLE next cycle; in-progress event discarded;
//             FIFO contents kept.
//   ARMED   : lowest lane r with t[r]=1 and prev sample 0 = rise. Latch ts={ltc_in,r[1:0]}, bsum_in;
//             length = contiguous 1s from r within word. Ends within word -> push event, HOLDOFF;
//             else -> OVER.
//   OVER    : each word adds contiguous 1s from lane 0. First 0 ends pulse -> push, HOLDOFF.
//             length reaching max_tot (max_tot!=0) -> push with flag[0], length=max_tot, HOLDOFF.
//             fvalid_in=0 ends the pulse and sets flag[1].
//   HOLDOFF : counts holdoff cycles, incl. the push cycle; then ARMED. Rises during HOLDOFF are
//             ignored, as are further rises in the word that ended the pulse. A pulse still high at
//             re-arm is not a rise (prev sample 1).
//  Length counter saturates at all-ones when max_tot=0.
//  FIFO: push occurs the cycle after the ending word is sampled; evt_valid rises the cycle after
//  push (2 cycles latency from end word). Simultaneous push and pop on a full FIFO is allowed (no drop).
//  Push when full and no pop: event dropped, drop_cnt++ (saturates). drop_cnt_clr wins over increment.
//  Outputs stable while evt_valid && !evt_ready. Empty pop is ignored.
// CONFIGURATION
//  FIR_TRIG_DISCR_PEAK_EN defined: per event, track the signed max of fout lanes where t[i]=1 within
//  the pulse; reported in evt_peak; FIFO stores it. Undefined: fout_in is unused, evt_peak tied 0,
//  no peak storage in the FIFO.
// TESTING
//  enable=1, holdoff=4, ltc=100, tot_in=1100 then 0000 -> one event ts={100,2}, tot=2, flags=0.
//  tot_in 1000@ltc=7, 1111, 0011 -> ts={7,3}, tot=7, evt_valid 2 cycles after 0011 word.
//  max_tot=5, tot_in=1111 held 4 words -> one event tot=5, flag[0]=1; no new event while held high.
//  tot_in 0110 then 0000, holdoff=10, second rise 3 cycles later -> only first event emitted.
//  evt_ready=0, 17 pulses, FIFO_DEPTH=16 -> 16 queued, drop_cnt=1; then ready=1 drains them in order.
//  During OVER drop fvalid_in -> event flag[1]=1; with PEAK_EN, fout peak 5000 -> evt_peak=5000.

Source files
------------

// File: rtl/fir_trig_discr_if.sv
// Event readout channel of fir_trig_discr: FIFO head plus valid/ready handshake.
interface fir_trig_discr_if #(
    parameter int CNT_BITS = 16
);
    logic                evt_valid;
    logic                evt_ready;
    logic [49:0]         evt_ts;
    logic [CNT_BITS-1:0] evt_tot;
    logic [17:0]         evt_bsum;
    logic [30:0]         evt_peak;
    logic [1:0]          evt_flags;

    modport master (
        output evt_valid, evt_ts, evt_tot, evt_bsum, evt_peak, evt_flags,
        input  evt_ready
    );
    modport slave (
        input  evt_valid, evt_ts, evt_tot, evt_bsum, evt_peak, evt_flags,
        output evt_ready
    );
endinterface

// File: rtl/fir_trig_discr.sv
// TOT discriminator: turns 4-lane TOT words into timestamped events queued in a FIFO.
// Optional peak tracking of the filtered samples is enabled by FIR_TRIG_DISCR_PEAK_EN.

module fir_trig_discr_lane (
    input  logic tot,
    input  logic fvalid,
    input  logic prev_t,
    output logic t,
    output logic rise
);
    assign t    = tot & fvalid;
    assign rise = t & ~prev_t;
endmodule

module fir_trig_discr #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          tot_in,
    input  logic                fvalid_in,
    input  logic [123:0]        fout_in,
    input  logic [17:0]         bsum_in,
    input  logic [47:0]         ltc_in,
    input  logic                enable,
    input  logic [CNT_BITS-1:0] holdoff,
    input  logic [CNT_BITS-1:0] max_tot,
    input  logic                drop_cnt_clr,
    fir_trig_discr_if.master    evt,
    output logic [CNT_BITS-1:0] drop_cnt
);
    localparam int NUM_LANES = 4;
    localparam int AW        = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_OVER    = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    typedef struct packed {
`ifdef FIR_TRIG_DISCR_PEAK_EN
        logic [30:0]         peak;
`endif
        logic [49:0]         ts;
        logic [CNT_BITS-1:0] tot;
        logic [17:0]         bsum;
        logic [1:0]          flags;
    } evt_t;

    logic [1:0]          state;
    logic                prev_t3;
    logic [CNT_BITS-1:0] len_q;
    logic [CNT_BITS-1:0] hold_cnt;
    logic                pend_vld;
    evt_t                pend;

    logic [NUM_LANES-1:0] t, rise, prev_vec;

    // Lane 0 compares against lane 3 of the previous word.
    assign prev_vec = {t[NUM_LANES-2:0], prev_t3};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fir_trig_discr_lane u_lane (
            .tot    (tot_in[i]),
            .fvalid (fvalid_in),
            .prev_t (prev_vec[i]),
            .t      (t[i]),
            .rise   (rise[i])
        );
    end

    logic                 rise_any;
    logic [1:0]           rise_lane;
    logic [1:0]           start;
    logic [NUM_LANES-1:0] run;
    logic [2:0]           run_len;
    logic                 still;
    logic                 cont;
    logic [CNT_BITS-1:0]  base;
    logic [CNT_BITS:0]    sum_w;
    logic [CNT_BITS-1:0]  len_sat;
    logic                 trunc;
    logic                 active;
    logic                 ended;

    always_comb begin
        rise_any  = 1'b0;
        rise_lane = 2'd0;
        for (int i = NUM_LANES-1; i >= 0; i--) begin
            if (rise[i]) begin
                rise_any  = 1'b1;
                rise_lane = 2'(i);
            end
        end

        // Contiguous run of ones starting at the rise lane (ARMED) or lane 0 (OVER).
        start   = (state == S_OVER) ? 2'd0 : rise_lane;
        run     = '0;
        run_len = 3'd0;
        still   = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i >= int'(start)) begin
                if (still && t[i]) begin
                    run[i]  = 1'b1;
                    run_len = run_len + 3'd1;
                end else begin
                    still = 1'b0;
                end
            end
        end
        cont = run[NUM_LANES-1];

        base    = (state == S_OVER) ? len_q : '0;
        sum_w   = {1'b0, base} + {{(CNT_BITS-2){1'b0}}, run_len};
        len_sat = sum_w[CNT_BITS] ? '1 : sum_w[CNT_BITS-1:0];
        // Truncate once the length passes max_tot, or meets it while still high.
        trunc   = (max_tot != '0) &&
                  ((len_sat > max_tot) || ((len_sat == max_tot) && cont));
        active  = ((state == S_ARMED) && rise_any) || (state == S_OVER);
        ended   = active && (!cont || trunc);
    end

    logic [49:0] ts_q, ts_nx;
    logic [17:0] bsum_q, bsum_nx;

    assign ts_nx   = (state == S_ARMED) ? {ltc_in, rise_lane} : ts_q;
    assign bsum_nx = (state == S_ARMED) ? bsum_in : bsum_q;

`ifdef FIR_TRIG_DISCR_PEAK_EN
    localparam logic signed [30:0] PEAK_MIN = 31'sh4000_0000;

    logic        [NUM_LANES-1:0][30:0] fout_l;
    logic signed [30:0]                peak_q, peak_nx;

    assign fout_l = fout_in;

    always_comb begin
        peak_nx = (state == S_OVER) ? peak_q : PEAK_MIN;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (run[i] && ($signed(fout_l[i]) > peak_nx))
                peak_nx = $signed(fout_l[i]);
        end
    end
`else
    logic unused_fout;
    assign unused_fout = ^fout_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            prev_t3  <= 1'b0;
            len_q    <= '0;
            hold_cnt <= '0;
            ts_q     <= '0;
            bsum_q   <= '0;
            pend_vld <= 1'b0;
            pend     <= '0;
`ifdef FIR_TRIG_DISCR_PEAK_EN
            peak_q   <= '0;
`endif
        end else begin
            prev_t3  <= (state == S_IDLE) ? 1'b0 : t[NUM_LANES-1];
            pend_vld <= 1'b0;
            if (!enable) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: state <= S_ARMED;
                    S_ARMED, S_OVER: begin
                        if (active) begin
                            len_q  <= len_sat;
                            ts_q   <= ts_nx;
                            bsum_q <= bsum_nx;
`ifdef FIR_TRIG_DISCR_PEAK_EN
                            peak_q <= peak_nx;
`endif
                            if (ended) begin
                                state      <= S_HOLDOFF;
                                hold_cnt   <= (holdoff == '0) ? '0 : holdoff - 1'b1;
                                pend_vld   <= 1'b1;
                                pend.ts    <= ts_nx;
                                pend.tot   <= trunc ? max_tot : len_sat;
                                pend.bsum  <= bsum_nx;
                                pend.flags <= {(state == S_OVER) && !fvalid_in && !trunc, trunc};
`ifdef FIR_TRIG_DISCR_PEAK_EN
                                pend.peak  <= peak_nx;
`endif
                            end else begin
                                state <= S_OVER;
                            end
                        end
                    end
                    S_HOLDOFF: begin
                        if (hold_cnt == '0) state <= S_ARMED;
                        else                hold_cnt <= hold_cnt - 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Event FIFO; pointers carry one wrap bit to tell full from empty.
    evt_t        mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push, drop;
    evt_t        head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && evt.evt_ready;
    assign push  = pend_vld && (!full || pop);
    assign drop  = pend_vld && full && !pop;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= pend;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop_cnt_clr)                 drop_cnt <= '0;
            else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign evt.evt_valid = !empty;
    assign evt.evt_ts    = head.ts;
    assign evt.evt_tot   = head.tot;
    assign evt.evt_bsum  = head.bsum;
    assign evt.evt_flags = head.flags;
`ifdef FIR_TRIG_DISCR_PEAK_EN
    assign evt.evt_peak  = head.peak;
`else
    assign evt.evt_peak  = '0;
`endif
endmodule
